// File: rtl/mem_arbiter_pkg.sv
// Shared types for the program/data RAM arbiter: owner encoding, bus widths
// and the one-stage read-return tag.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_FULL_W = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned MEM_DEPTH   = 512;

    typedef logic [ADDR_FULL_W-1:0] addr_t;
    typedef logic [DATA_W-1:0]      data_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } arb_owner_t;

    typedef struct packed {
        logic       is_read;
        logic       oor;
        arb_owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed priority to requester 0
// when prio_mode is set. Requester 0 is the CPU, requester 1 the debug unit.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_mode,
    output logic [1:0] gnt
);

    logic last_dbg_q;
    logic last_dbg_d;

    always_comb begin
        gnt        = 2'b00;
        last_dbg_d = last_dbg_q;
        if (req == 2'b11) begin
            gnt = (prio_mode || last_dbg_q) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
        // Pointer only moves when someone was actually served.
        if (gnt != 2'b00) begin
            last_dbg_d = gnt[1];
        end
    end

    // Reset points at debug so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port program/data RAM between the CPU (port C) and the
// debug/loader unit (port D), one access per cycle, read data tagged to owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned CPU_PRIO = 0,
    parameter logic [7:0]  OOR_DATA = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [15:0]       c_addr,
    input  logic [7:0]        c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [7:0]        c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [15:0]       d_addr,
    input  logic [7:0]        d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [7:0]        d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_stall,
    output logic [1:0]        owner
);

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    addr_t      sel_addr;
    data_t      sel_wdata;
    logic       sel_we;
    logic       in_range;
    data_t      rd_val;
    rd_tag_t    tag_q;
    rd_tag_t    tag_d;
    data_t      c_hold_q;
    data_t      c_hold_d;
    data_t      d_hold_q;
    data_t      d_hold_d;

    // Requests are masked while in reset so nothing is granted or issued.
    assign arb_req = {d_req, c_req} & {2{rst}};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .prio_mode (CPU_PRIO != 0),
        .gnt       (arb_gnt)
    );

    always_comb begin
        c_gnt     = arb_gnt[0];
        d_gnt     = arb_gnt[1];
        sel_addr  = arb_gnt[1] ? d_addr  : c_addr;
        sel_wdata = arb_gnt[1] ? d_wdata : c_wdata;
        sel_we    = arb_gnt[1] ? d_we    : c_we;
        in_range  = (sel_addr >> ADDR_W) == 16'(0);
        mem_en    = (|arb_gnt) & in_range;
        mem_we    = mem_en & sel_we;
        mem_addr  = sel_addr[ADDR_W-1:0];
        mem_wdata = sel_wdata;
        cpu_stall = c_req & rst & ~arb_gnt[0];
        owner     = arb_gnt[0] ? OWN_CPU : (arb_gnt[1] ? OWN_DBG : OWN_NONE);

        tag_d.is_read = (|arb_gnt) & ~sel_we;
        tag_d.oor     = ~in_range;
        tag_d.owner   = arb_owner_t'(owner);
    end

    // Read return: rvalid is masked by rst so an in-flight pulse dies with reset.
    always_comb begin
        rd_val   = tag_q.oor ? OOR_DATA : mem_rdata;
        c_rvalid = rst & tag_q.is_read & (tag_q.owner == OWN_CPU);
        d_rvalid = rst & tag_q.is_read & (tag_q.owner == OWN_DBG);
        c_rdata  = c_rvalid ? rd_val : c_hold_q;
        d_rdata  = d_rvalid ? rd_val : d_hold_q;
        c_hold_d = c_rdata;
        d_hold_d = d_rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q    <= '0;
            c_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            tag_q    <= tag_d;
            c_hold_q <= c_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a RAM model and
// a CPU-priority instance sharing the same stimulus.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, d_addr;
    logic [7:0]  c_wdata, d_wdata;

    logic        r_c_gnt, r_c_rvalid, r_d_gnt, r_d_rvalid, r_mem_en, r_mem_we, r_cpu_stall;
    logic [7:0]  r_c_rdata, r_d_rdata, r_mem_wdata, r_mem_rdata;
    logic [8:0]  r_mem_addr;
    logic [1:0]  r_owner;

    logic        p_c_gnt, p_c_rvalid, p_d_gnt, p_d_rvalid, p_mem_en, p_mem_we, p_cpu_stall;
    logic [7:0]  p_c_rdata, p_d_rdata, p_mem_wdata;
    logic [8:0]  p_mem_addr;
    logic [1:0]  p_owner;

    logic [7:0]  mem0 [512];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    mem_arbiter #(.ADDR_W(9), .CPU_PRIO(0), .OOR_DATA(8'hFF)) u_rr (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(r_c_gnt), .c_rvalid(r_c_rvalid), .c_rdata(r_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
        .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata),
        .cpu_stall(r_cpu_stall), .owner(r_owner)
    );

    mem_arbiter #(.ADDR_W(9), .CPU_PRIO(1), .OOR_DATA(8'hFF)) u_pr (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(p_c_gnt), .c_rvalid(p_c_rvalid), .c_rdata(p_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
        .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
        .mem_wdata(p_mem_wdata), .mem_rdata(8'h00),
        .cpu_stall(p_cpu_stall), .owner(p_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port RAM model for the round-robin instance.
    always @(posedge clk) begin
        if (r_mem_en) begin
            if (r_mem_we) mem0[r_mem_addr] <= r_mem_wdata;
            else          r_mem_rdata      <= mem0[r_mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem0[i] = 8'h00;
        mem0[9'h0A0] = 8'hA6;
        mem0[9'h100] = 8'h3C;
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0000; c_wdata = 8'h00;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 8'h00;

        // Reset held with both ports requesting.
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk("rst_c_gnt",    16'(r_c_gnt),     16'h0);
            chk("rst_d_gnt",    16'(r_d_gnt),     16'h0);
            chk("rst_mem_en",   16'(r_mem_en),    16'h0);
            chk("rst_mem_we",   16'(r_mem_we),    16'h0);
            chk("rst_c_rvalid", 16'(r_c_rvalid),  16'h0);
            chk("rst_d_rvalid", 16'(r_d_rvalid),  16'h0);
            chk("rst_stall",    16'(r_cpu_stall), 16'h0);
            chk("rst_owner",    16'(r_owner),     16'(OWN_NONE));
        end
        rst = 1'b1; #1;
        chk("rel_c_gnt", 16'(r_c_gnt), 16'h1);
        chk("rel_d_gnt", 16'(r_d_gnt), 16'h0);
        chk("rel_owner", 16'(r_owner), 16'(OWN_CPU));
        chk("rel_stall", 16'(r_cpu_stall), 16'h0);

        step(); c_req = 1'b0; d_req = 1'b0; #2;
        chk("rel_c_rvalid", 16'(r_c_rvalid), 16'h1);
        chk("rel_c_rdata",  16'(r_c_rdata),  16'h00);
        chk("rel_d_rvalid", 16'(r_d_rvalid), 16'h0);

        // Single CPU read.
        step(); c_req = 1'b1; c_addr = 16'h00A0; #2;
        chk("crd_gnt",   16'(r_c_gnt),    16'h1);
        chk("crd_en",    16'(r_mem_en),   16'h1);
        chk("crd_addr",  16'(r_mem_addr), 16'h0A0);
        chk("crd_stall", 16'(r_cpu_stall), 16'h0);

        // Read return while D issues a write.
        step(); c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 8'h5A; #2;
        chk("crd_rvalid", 16'(r_c_rvalid), 16'h1);
        chk("crd_rdata",  16'(r_c_rdata),  16'h00A6);
        chk("crd_drv",    16'(r_d_rvalid), 16'h0);
        chk("dwr_gnt",    16'(r_d_gnt),    16'h1);
        chk("dwr_we",     16'(r_mem_we),   16'h1);
        chk("dwr_wdata",  16'(r_mem_wdata), 16'h005A);
        chk("dwr_owner",  16'(r_owner),    16'(OWN_DBG));

        step(); d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_addr = 16'h0010; #2;
        chk("c10_gnt",    16'(r_c_gnt),    16'h1);
        chk("dwr_norv",   16'(r_d_rvalid), 16'h0);
        chk("dwr_nocrv",  16'(r_c_rvalid), 16'h0);

        // Read-after-write, then D reads out of range.
        step(); c_req = 1'b0; d_req = 1'b1; d_addr = 16'h0200; #2;
        chk("c10_rvalid", 16'(r_c_rvalid), 16'h1);
        chk("c10_rdata",  16'(r_c_rdata),  16'h005A);
        chk("oor_gnt",    16'(r_d_gnt),    16'h1);
        chk("oor_en",     16'(r_mem_en),   16'h0);

        step(); d_we = 1'b1; d_addr = 16'h0300; d_wdata = 8'h77; #2;
        chk("oor_rvalid", 16'(r_d_rvalid), 16'h1);
        chk("oor_rdata",  16'(r_d_rdata),  16'h00FF);
        chk("oorw_gnt",   16'(r_d_gnt),    16'h1);
        chk("oorw_en",    16'(r_mem_en),   16'h0);
        chk("oorw_we",    16'(r_mem_we),   16'h0);

        step(); d_req = 1'b0; d_we = 1'b0; #2;
        chk("oorw_norv",  16'(r_d_rvalid), 16'h0);
        chk("oorw_ram",   16'(mem0[9'h100]), 16'h003C);
        chk("c_hold",     16'(r_c_rdata),  16'h005A);
        chk("d_hold",     16'(r_d_rdata),  16'h00FF);

        // Both ports continuously reading.
        for (int k = 0; k < 6; k++) begin
            step();
            c_req = 1'b1; c_we = 1'b0; c_addr = 16'h00A0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; #2;
            chk("rr_c_gnt",  16'(r_c_gnt),     16'(k % 2 == 0));
            chk("rr_d_gnt",  16'(r_d_gnt),     16'(k % 2 == 1));
            chk("rr_stall",  16'(r_cpu_stall), 16'(k % 2 == 1));
            chk("rr_c_rv",   16'(r_c_rvalid),  16'(k % 2 == 1));
            chk("rr_d_rv",   16'(r_d_rvalid),  16'(k > 0 && k % 2 == 0));
            if (k % 2 == 1) chk("rr_c_rdata", 16'(r_c_rdata), 16'h00A6);
            if (k > 0 && k % 2 == 0) chk("rr_d_rdata", 16'(r_d_rdata), 16'h005A);
            chk("pr_c_gnt",  16'(p_c_gnt),     16'h1);
            chk("pr_d_gnt",  16'(p_d_gnt),     16'h0);
            chk("pr_stall",  16'(p_cpu_stall), 16'h0);
        end
        step(); c_req = 1'b0; d_req = 1'b0; #2;
        chk("rr_last_d_rv", 16'(r_d_rvalid), 16'h1);
        chk("rr_last_d_rd", 16'(r_d_rdata),  16'h005A);
        chk("rr_last_c_rv", 16'(r_c_rvalid), 16'h0);

        // Reset during the cycle the read data is due.
        step(); c_req = 1'b1; c_addr = 16'h00A0; #2;
        chk("mid_gnt", 16'(r_c_gnt), 16'h1);
        step(); c_req = 1'b0; rst = 1'b0; #2;
        chk("mid_norv", 16'(r_c_rvalid), 16'h0);
        step(); rst = 1'b1; #2;
        chk("mid_after_rv", 16'(r_c_rvalid), 16'h0);
        chk("mid_rdata",    16'(r_c_rdata),  16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
